// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the MIPS CPU data port.
// Accepts one load/store at a time over req/ack, waits WAIT_CYCLES cycles,
// commits a byte-enabled access to a word array, and pulses ack for one cycle.
// Optional build macro: DMEM_RESP_ERR_EN flags misaligned or out-of-range
// addresses with err instead of committing them. Without it, err is tied low
// and the address wraps modulo DEPTH_WORDS.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;

  // Request fields captured in IDLE and held through WAIT.
  logic            cap_we;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_wdata;
  logic [3:0]      cap_be;
  logic            cap_bad;

  // Fields of the access being committed this cycle.
  logic            a_we;
  logic [AW-1:0]   a_idx;
  logic [31:0]     a_wdata;
  logic [3:0]      a_be;
  logic            a_bad;

  logic [AW-1:0]   in_idx;
  logic            in_bad;
  logic            commit;
  logic [31:0]     old_word;

  logic [31:0]     mem [DEPTH_WORDS];

  assign in_idx = addr[AW+1:2];

`ifdef DMEM_RESP_ERR_EN
  assign in_bad = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  // Byte offset and upper address bits are deliberately ignored (wrap-around).
  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign in_bad      = 1'b0;
`endif

  // Select the access fields: live inputs when committing straight from IDLE
  // (zero wait states), captured fields otherwise.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    a_we    = cap_we;
    a_idx   = cap_idx;
    a_wdata = cap_wdata;
    a_be    = cap_be;
    a_bad   = cap_bad;
    if (state == IDLE) begin
      a_we    = we;
      a_idx   = in_idx;
      a_wdata = wdata;
      a_be    = be;
      a_bad   = in_bad;
    end
  end

  // The access commits on the last WAIT cycle, or on the capture edge when
  // there are no wait states. Gated by clrn so nothing is written in reset.
  assign commit = clrn &&
                  (((state == WAIT) && (cnt == 4'd1)) ||
                   ((WAIT_CYCLES == 0) && (state == IDLE) && req));

  assign old_word = mem[a_idx];

  // Byte-lane write of a committed, error-free store.
  // NOTE: the array has no reset; clearing it would need a per-word reset
  // network and stop it mapping onto RAM. Contents are undefined after power-up.
  always_ff @(posedge clk) begin
    if (commit && a_we && !a_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  // Handshake FSM with registered ack/rdata/err and request capture.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ack       <= 1'b0;
      rdata     <= 32'd0;
      err       <= 1'b0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
      cap_bad   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples pre-edge values regardless of statement order.
      ack <= 1'b0;
      if (commit) begin
        rdata <= a_bad ? 32'd0 : old_word;
        err   <= a_bad;
      end
      case (state)
        IDLE: begin
          if (req) begin
            cap_we    <= we;
            cap_idx   <= in_idx;
            cap_wdata <= wdata;
            cap_be    <= be;
            cap_bad   <= in_bad;
            cnt       <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
              ack   <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            ack   <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// A transaction-level model (timestamped pending access, word array) predicts
// ack/rdata/err every cycle; directed sequences pin the model with literals.
// A second instance with zero wait states covers the fast path.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic        clk;
  logic        clrn;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack, err;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic [31:0] rdata0;
  logic        ack0, err0;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .clrn(clrn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .ack(ack), .err(err)
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .clrn(clrn), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .be(be0), .rdata(rdata0), .ack(ack0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          commit_edge;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } acc_t;

  acc_t        pend[$];
  logic [31:0] mm       [DEPTH];
  logic        mm_known [DEPTH];
  int          edge_n    = 0;
  int          free_edge = 0;
  logic        exp_ack   = 1'b0;
  logic        exp_err   = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_known = 1'b1;
  logic        chk_en    = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) mm_known[i] = 1'b0;

  function automatic logic is_bad(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
    return ((a % 32'd4) != 32'd0) || ((a >> 2) >= 32'(DEPTH));
`else
    return (a == 32'hFFFF_FFFF) && (a != a);
`endif
  endfunction

  always @(posedge clk or negedge clrn) begin : model
    acc_t        t;
    int          wi;
    logic [31:0] m;
    if (!clrn) begin
      pend.delete();
      exp_ack   = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = 32'd0;
      exp_known = 1'b1;
      free_edge = edge_n + 1;
    end else begin
      edge_n++;
      exp_ack = 1'b0;
      if (req && edge_n >= free_edge) begin
        pend.push_back('{edge_n + W, we, addr, wdata, be});
        free_edge = edge_n + W + 2;
      end
      if (pend.size() > 0 && pend[0].commit_edge == edge_n) begin
        t       = pend.pop_front();
        wi      = int'((t.addr >> 2) % 32'(DEPTH));
        exp_ack = 1'b1;
        if (is_bad(t.addr)) begin
          exp_rdata = 32'd0;
          exp_err   = 1'b1;
          exp_known = 1'b1;
        end else begin
          exp_rdata = mm[wi];
          exp_known = mm_known[wi];
          exp_err   = 1'b0;
          if (t.we) begin
            m = {{8{t.be[3]}}, {8{t.be[2]}}, {8{t.be[1]}}, {8{t.be[0]}}};
            mm[wi] = (mm[wi] & ~m) | (t.wdata & m);
            if (t.be == 4'hF) mm_known[wi] = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", {31'd0, ack}, {31'd0, exp_ack});
      check("err", {31'd0, err}, {31'd0, exp_err});
      if (exp_known) check("rdata", rdata, exp_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output int lat, output logic [31:0] rd,
                     output logic er);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    lat = -1; rd = 32'd0; er = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (ack) begin
        lat = c; rd = rdata; er = err;
        break;
      end
    end
    if (lat < 0) check("txn_timeout", 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int          r;
    a = 32'($urandom_range(0, 15)) << 2;
    r = $urandom_range(0, 9);
`ifdef DMEM_RESP_ERR_EN
    if (r == 0) a = a | 32'($urandom_range(1, 3));
    else if (r == 1) a = a + 32'(DEPTH * 4 * $urandom_range(1, 3));
`else
    if (r < 5) a = a | ($urandom & ~(32'(DEPTH - 1) << 2));
`endif
    return a;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [31:0] pre [16];
    logic [15:0] pat;
    logic [7:0]  pat0;

    clrn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_ack",   {31'd0, ack}, 32'd0);
    check("reset_rdata", rdata,        32'd0);
    check("reset_err",   {31'd0, err}, 32'd0);
    #2 clrn = 1'b1;
    @(negedge clk);

    // Fill the words used below with known data.
    for (int i = 0; i < 16; i++) begin
      pre[i] = $urandom;
      txn(1'b1, 32'(i * 4), pre[i], 4'hF, lat, rd, er);
    end

    // Full-word store then load.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    check("st_lat", 32'(lat), 32'd3);
    txn(1'b0, 32'h10, 32'd0, 4'h0, lat, rd, er);
    check("ld_lat",   32'(lat),     32'd3);
    check("ld_rdata", rd,           32'hDEADBEEF);
    check("ld_err",   {31'd0, er},  32'd0);

    // Byte enables: lanes 0 and 2 only; store returns the pre-write word.
    txn(1'b1, 32'h10, 32'h11223344, 4'h5, lat, rd, er);
    check("be_st_old", rd, 32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'd0, 4'h0, lat, rd, er);
    check("be_ld", rd, 32'hDE22BE44);
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, lat, rd, er);
    check("be0_lat", 32'(lat), 32'd3);
    txn(1'b0, 32'h10, 32'd0, 4'h0, lat, rd, er);
    check("be0_ld", rd, 32'hDE22BE44);

    // Back-to-back loads with req held high: four one-cycle acks, 4 apart.
    req = 1'b1; we = 1'b0; addr = 32'h10; pat = '0; rd = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      pat[c-1] = ack;
      if (c == 3) rd = rdata;
      if (c == 13) req = 1'b0;
    end
    check("b2b_pattern", {16'd0, pat}, 32'h0000_4444);
    check("b2b_rdata",   rd,           32'hDE22BE44);

    // Reset during WAIT drops the pending store.
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    #2 clrn = 1'b0;
    #1;
    check("rst_ack",   {31'd0, ack}, 32'd0);
    check("rst_rdata", rdata,        32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    @(negedge clk);
    #2 clrn = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h20, 32'd0, 4'h0, lat, rd, er);
    check("rst_keep", rd, pre[8]);

    // Out-of-range store: error in the checked build, alias of word 0 otherwise.
    txn(1'b1, 32'h0, 32'h01234567, 4'hF, lat, rd, er);
    txn(1'b1, 32'(DEPTH * 4), 32'h89ABCDEF, 4'hF, lat, rd, er);
`ifdef DMEM_RESP_ERR_EN
    check("oor_err", {31'd0, er}, 32'd1);
    txn(1'b0, 32'h0, 32'd0, 4'h0, lat, rd, er);
    check("oor_word0", rd, 32'h01234567);
    txn(1'b0, 32'h13, 32'd0, 4'h0, lat, rd, er);
    check("mis_err",   {31'd0, er}, 32'd1);
    check("mis_rdata", rd,          32'd0);
    check("mis_lat",   32'(lat),    32'd3);
`else
    check("oor_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h0, 32'd0, 4'h0, lat, rd, er);
    check("oor_word0", rd, 32'h89ABCDEF);
`endif

    // Randomised traffic with occasional asynchronous reset pulses.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 99) < 55);
      we    = 1'($urandom);
      wdata = $urandom;
      be    = 4'($urandom);
      addr  = rand_addr();
      if ($urandom_range(0, 249) == 0) begin
        #1 clrn = 1'b0;
        #2 clrn = 1'b1;
      end
    end
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);

    // Zero-wait-state instance: ack in cycle 1, one access per 2 cycles.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hA5A50F0F; be0 = 4'hF;
    @(negedge clk);
    req0 = 1'b0;
    check("w0_st_ack", {31'd0, ack0}, 32'd1);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; pat0 = '0; rd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      pat0[c-1] = ack0;
      if (c == 1) rd = rdata0;
      if (c == 7) req0 = 1'b0;
    end
    check("w0_pattern", {24'd0, pat0}, 32'h0000_0055);
    check("w0_rdata",   rd,            32'hA5A50F0F);
    check("w0_err",     {31'd0, err0}, 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
